pow2_stage_counter: RTL and testbench

//  Parametrised successor to the 9-bit sequencing counter in the spectrum analyser datapath.

---
 rtl/spectrum_pkg.sv | 16 +
 rtl/start_edge_det.sv | 29 ++
 rtl/pow2_stage_counter.sv | 109 ++++++++++
 tb/tb_pow2_stage_counter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum analyser sequencing logic:
// state encoding and the default counter width used by the FFT stage control.
package spectrum_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Default sequencing width, shared with the FFT stage control.
    localparam int DEFAULT_WIDTH = 9;

    typedef enum logic {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/start_edge_det.sv
// Registered rising-edge detector for the start request.
// The history flop updates every cycle, so a level held high yields one pulse.
module start_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    // Next history value is simply the current input.
    always_comb begin
        din_d = din;
    end

    // History register, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/pow2_stage_counter.sv
// Power-of-two stage counter: WIDTH-bit up-counter with start/stop/en control,
// one-shot or continuous mode, registered power-of-two boundary strobes (md)
// and a done strobe on the terminal advance.
module pow2_stage_counter
    import spectrum_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int START_EDGE = 1
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             cont,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] md,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] md_q;
    logic [WIDTH-1:0] md_d;
    logic             done_q;
    logic             done_d;

    logic [WIDTH-1:0] md_hit;
    logic             start_rise;
    logic             trig;
    logic             terminal;

    start_edge_det u_start_edge_det (
        .clk     (Clk),
        .reset_n (reset_n),
        .din     (start),
        .rise    (start_rise)
    );

    // Level-sensitive builds ignore the edge detector and use start directly.
    assign trig = (START_EDGE != 0) ? start_rise : start;

    // md[k] is armed when the low k+1 count bits are all ones: the next
    // advance closes a 2**(k+1)-advance block.
    for (genvar k = 0; k < WIDTH; k++) begin : g_md
        assign md_hit[k] = &count_q[k:0];
    end

    assign terminal = md_hit[WIDTH-1];

    // Next-state, next-count and strobe computation; stop overrides everything.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        md_d    = '0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (trig) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        count_d = count_q + WIDTH'(1);
                        md_d    = md_hit;
                        done_d  = terminal;
                        if (terminal && !cont) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, counter and strobe registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            md_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            md_q    <= md_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign md    = md_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_pow2_stage_counter.sv
// Directed testbench for pow2_stage_counter (WIDTH=9), with one edge-triggered
// and one level-triggered instance sharing the same stimulus.
module tb_pow2_stage_counter;

    localparam int W = 9;
    localparam int N = 512;

    logic         Clk;
    logic         reset_n;
    logic         start;
    logic         stop;
    logic         en;
    logic         cont;
    logic [W-1:0] count_e;
    logic [W-1:0] md_e;
    logic         busy_e;
    logic         done_e;
    logic [W-1:0] count_l;
    logic [W-1:0] md_l;
    logic         busy_l;
    logic         done_l;

    int n_checks = 0;
    int n_errors = 0;

    pow2_stage_counter #(.WIDTH(W), .START_EDGE(1)) dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .en      (en),
        .cont    (cont),
        .count   (count_e),
        .md      (md_e),
        .busy    (busy_e),
        .done    (done_e)
    );

    pow2_stage_counter #(.WIDTH(W), .START_EDGE(0)) dut_lvl (
        .Clk     (Clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .en      (en),
        .cont    (cont),
        .count   (count_l),
        .md      (md_l),
        .busy    (busy_l),
        .done    (done_l)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected md after advance number a (a >= 1): bit k set when a closes a 2**(k+1) block.
    function automatic logic [W-1:0] md_exp(input int a);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) begin
            r[k] = (a > 0) && ((a % (1 << (k + 1))) == 0);
        end
        return r;
    endfunction

    initial begin
        int md0_n;
        int md3_n;
        int md8_n;
        int done_n;
        int de_n;
        int dl_n;
        int idle_l_n;
        int a;

        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        en      = 1'b0;
        cont    = 1'b0;
        tick();
        tick();
        check("rst_count", count_e, 0);
        check("rst_md", md_e, 0);
        check("rst_busy", busy_e, 0);
        check("rst_done", done_e, 0);

        // One-shot, en held high, single start pulse.
        reset_n = 1'b1;
        en      = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_start", busy_e, 1);
        check("t1_count_start", count_e, 0);
        check("t1_done_start", done_e, 0);
        md0_n = 0;
        md3_n = 0;
        md8_n = 0;
        for (int i = 1; i <= N; i++) begin
            tick();
            check("t1_count", count_e, i % N);
            check("t1_md", md_e, md_exp(i));
            check("t1_done", done_e, (i == N));
            check("t1_busy", busy_e, (i < N));
            if (md_e[0]) md0_n++;
            if (md_e[3]) md3_n++;
            if (md_e[8]) md8_n++;
        end
        check("t2_md0_pulses", md0_n, 256);
        check("t2_md3_pulses", md3_n, 32);
        check("t2_md8_pulses", md8_n, 1);
        tick();
        check("t1_idle_busy", busy_e, 0);
        check("t1_idle_count", count_e, 0);
        check("t1_idle_done", done_e, 0);

        // en toggling: advance only on odd cycles.
        en    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_busy_start", busy_e, 1);
        for (int c = 1; c <= 2 * N - 1; c++) begin
            en = (c % 2 == 1);
            tick();
            a = (c + 1) / 2;
            check("t3_count", count_e, a % N);
            check("t3_md", md_e, (c % 2 == 1) ? md_exp(a) : '0);
            check("t3_done", done_e, (c == 2 * N - 1));
            check("t3_busy", busy_e, (c < 2 * N - 1));
        end
        en = 1'b1;

        // Continuous mode for 1100 advances, then stop.
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        done_n = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            check("t4_count", count_e, i % N);
            check("t4_busy", busy_e, 1);
            check("t4_done", done_e, (i % N == 0));
            if (done_e) done_n++;
        end
        check("t4_done_pulses", done_n, 2);
        check("t4_final_count", count_e, 76);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_stop_busy", busy_e, 0);
        check("t4_stop_count", count_e, 0);
        check("t4_stop_done", done_e, 0);
        check("t4_stop_md", md_e, 0);
        cont = 1'b0;

        // start held high 2000 cycles: edge instance runs once, level instance repeats.
        reset_n = 1'b0;
        tick();
        reset_n  = 1'b1;
        start    = 1'b1;
        de_n     = 0;
        dl_n     = 0;
        idle_l_n = 0;
        for (int c = 1; c <= 2000; c++) begin
            tick();
            if (done_e) de_n++;
            if (done_l) dl_n++;
            if (!busy_l) idle_l_n++;
            if (c == 513) check("t5_lvl_gap_idle", busy_l, 0);
            if (c == 514) check("t5_lvl_gap_rerun", busy_l, 1);
        end
        check("t5_edge_done_pulses", de_n, 1);
        check("t5_edge_busy_end", busy_e, 0);
        check("t5_lvl_done_pulses", dl_n, 3);
        check("t5_lvl_idle_cycles", idle_l_n, 3);

        // Reset mid-sequence.
        start   = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (300) tick();
        check("t6_count_300", count_e, 300);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_rst_count", count_e, 0);
        check("t6_rst_md", md_e, 0);
        check("t6_rst_busy", busy_e, 0);
        check("t6_rst_done", done_e, 0);
        check("t6_rst_lvl_busy", busy_l, 0);

        // stop coincident with the terminal advance.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N - 1) tick();
        check("t6_pre_stop_count", count_e, N - 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6_stop_done", done_e, 0);
        check("t6_stop_md", md_e, 0);
        check("t6_stop_count", count_e, 0);
        check("t6_stop_busy", busy_e, 0);

        // start edge coincident with the one-shot terminal advance.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N - 1) tick();
        check("t6_pre_term_count", count_e, N - 1);
        start = 1'b1;
        tick();
        check("t6_term_done", done_e, 1);
        check("t6_term_md", md_e, 9'h1FF);
        check("t6_term_busy", busy_e, 0);
        tick();
        check("t6_no_restart_busy", busy_e, 0);
        check("t6_no_restart_count", count_e, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_new_edge_busy", busy_e, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
